// File: rtl/tensor_mem_responder_if.sv
// rtl/tensor_mem_responder_if.sv - tensor read/write burst channel bundle (AR, R, AW, W, B)
// Ports: none; carries the address/data/response handshake signals.
// Modports: master = tensor-side initiator, slave = memory-side responder.
interface tensor_mem_responder_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
);
    logic [ADDR_W-1:0] ar_addr;
    logic [LEN_W-1:0]  ar_len;
    logic              ar_valid;
    logic              ar_ready;
    logic [DATA_W-1:0] r_data;
    logic              r_last;
    logic              r_valid;
    logic              r_ready;
    logic [ADDR_W-1:0] aw_addr;
    logic [LEN_W-1:0]  aw_len;
    logic              aw_valid;
    logic              aw_ready;
    logic [DATA_W-1:0] w_data;
    logic              w_last;
    logic              w_valid;
    logic              w_ready;
    logic              b_resp;
    logic              b_valid;
    logic              b_ready;

    modport master (
        output ar_addr, ar_len, ar_valid, input ar_ready,
        input  r_data, r_last, r_valid, output r_ready,
        output aw_addr, aw_len, aw_valid, input aw_ready,
        output w_data, w_last, w_valid, input w_ready,
        input  b_resp, b_valid, output b_ready
    );

    modport slave (
        input  ar_addr, ar_len, ar_valid, output ar_ready,
        output r_data, r_last, r_valid, input r_ready,
        input  aw_addr, aw_len, aw_valid, output aw_ready,
        input  w_data, w_last, w_valid, output w_ready,
        output b_resp, b_valid, input b_ready
    );
endinterface

// File: rtl/tensor_mem_responder.sv
// rtl/tensor_mem_responder.sv - word-addressed tensor buffer answering read/write bursts
// Ports:
//   clock   - single rising-edge clock
//   reset_n - synchronous active-low reset (memory contents are kept)
//   bus     - slave side of tensor_mem_responder_if: AR/R read bursts, AW/W/B write bursts
module tensor_mem_responder #(
    parameter int DEPTH  = 2048,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    tensor_mem_responder_if.slave bus
);
    // DEPTH is a power of two, so "address mod DEPTH" is the low IDX_W bits.
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD      = 2'd1,
        ST_WR      = 2'd2,
        ST_WR_RESP = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;      // reads: beats left after the current one; writes: aw_len
    logic [LEN_W-1:0]  beat_q, beat_d;
    logic              err_q, err_d;      // an early w_last was seen in this write burst
    logic [DATA_W-1:0] r_data_q, r_data_d;
    logic              r_valid_q, r_valid_d;
    logic              r_last_q, r_last_d;
    logic              b_valid_q, b_valid_d;
    logic              b_resp_q, b_resp_d;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              mem_we;
    logic [IDX_W-1:0]  mem_widx;

    function automatic logic [IDX_W-1:0] to_idx(input logic [ADDR_W-1:0] a);
        return IDX_W'(a);
    endfunction

    // State register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            beat_q    <= '0;
            err_q     <= 1'b0;
            r_data_q  <= '0;
            r_valid_q <= 1'b0;
            r_last_q  <= 1'b0;
            b_valid_q <= 1'b0;
            b_resp_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            beat_q    <= beat_d;
            err_q     <= err_d;
            r_data_q  <= r_data_d;
            r_valid_q <= r_valid_d;
            r_last_q  <= r_last_d;
            b_valid_q <= b_valid_d;
            b_resp_q  <= b_resp_d;
        end
    end

    // Memory is never cleared; a beat presented on the reset edge is dropped.
    always_ff @(posedge clock) begin
        if (reset_n && mem_we) begin
            mem[mem_widx] <= bus.w_data;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        beat_d    = beat_q;
        err_d     = err_q;
        r_data_d  = r_data_q;
        r_valid_d = r_valid_q;
        r_last_d  = r_last_q;
        b_valid_d = b_valid_q;
        b_resp_d  = b_resp_q;
        mem_we    = 1'b0;
        mem_widx  = to_idx(ptr_q + ADDR_W'(beat_q));

        unique case (state_q)
            ST_IDLE: begin
                // Read has priority when both requests arrive together.
                if (bus.ar_valid) begin
                    ptr_d     = bus.ar_addr;
                    cnt_d     = bus.ar_len;
                    r_data_d  = mem[to_idx(bus.ar_addr)];
                    r_valid_d = 1'b1;
                    r_last_d  = (bus.ar_len == '0);
                    state_d   = ST_RD;
                end else if (bus.aw_valid) begin
                    ptr_d   = bus.aw_addr;
                    cnt_d   = bus.aw_len;
                    beat_d  = '0;
                    err_d   = 1'b0;
                    state_d = ST_WR;
                end
            end
            ST_RD: begin
                if (r_valid_q && bus.r_ready) begin
                    if (r_last_q) begin
                        r_valid_d = 1'b0;
                        r_last_d  = 1'b0;
                        state_d   = ST_IDLE;
                    end else begin
                        ptr_d    = ptr_q + ADDR_W'(1);
                        cnt_d    = cnt_q - LEN_W'(1);
                        r_data_d = mem[to_idx(ptr_q + ADDR_W'(1))];
                        r_last_d = (cnt_q == LEN_W'(1));
                    end
                end
            end
            ST_WR: begin
                if (bus.w_valid) begin
                    mem_we = 1'b1;
                    beat_d = beat_q + LEN_W'(1);
                    // The burst length comes from aw_len only; w_last just grades it.
                    if (beat_q == cnt_q) begin
                        b_valid_d = 1'b1;
                        b_resp_d  = bus.w_last && !err_q;
                        state_d   = ST_WR_RESP;
                    end else if (bus.w_last) begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_WR_RESP: begin
                if (bus.b_ready) begin
                    b_valid_d = 1'b0;
                    b_resp_d  = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        bus.ar_ready = (state_q == ST_IDLE);
        bus.aw_ready = (state_q == ST_IDLE) && !bus.ar_valid;
        bus.w_ready  = (state_q == ST_WR);
        bus.r_data   = r_data_q;
        bus.r_valid  = r_valid_q;
        bus.r_last   = r_last_q;
        bus.b_valid  = b_valid_q;
        bus.b_resp   = b_resp_q;
    end
endmodule
